// File: rtl/tracker_channel_sequencer.sv
// Row sequencer for one tracker voice: fetch row, decode, look up note frequency, apply to DDS channel.
// A row is applied 4 cycles after its fetch; the row period is max(ticks_per_row, 8) cycles and there is no backpressure.
module tracker_channel_sequencer #(
    parameter int PHASE_WIDTH    = 32,
    parameter int ROW_ADDR_WIDTH = 6,
    parameter int TICK_WIDTH     = 24
) (
    input  logic                      clk,
    input  logic                      rst_active_low,
    input  logic                      start,
    input  logic                      stop,
    input  logic [ROW_ADDR_WIDTH-1:0] last_row,
    input  logic [TICK_WIDTH-1:0]     ticks_per_row,
    output logic [ROW_ADDR_WIDTH-1:0] row_addr,
    output logic                      row_rd_en,
    input  logic [15:0]               row_data,
    output logic [6:0]                freq_rom_addr,
    output logic                      freq_rom_rd_en,
    input  logic [PHASE_WIDTH-1:0]    freq_rom_data,
    output logic [PHASE_WIDTH-1:0]    freq_word,
    output logic                      dds_phase_rst,
    output logic                      gate,
    output logic [3:0]                volume,
    output logic                      running,
    output logic                      row_strobe,
    output logic [ROW_ADDR_WIDTH-1:0] current_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOOKUP,
        S_APPLY,
        S_WAIT_TICK
    } state_t;

    localparam logic [1:0] CMD_NOTE_ON  = 2'b01;
    localparam logic [1:0] CMD_NOTE_OFF = 2'b10;
    localparam logic [1:0] CMD_JUMP     = 2'b11;

    localparam logic [TICK_WIDTH-1:0]     MIN_TICKS = TICK_WIDTH'(8);
    localparam logic [TICK_WIDTH-1:0]     ONE_TICK  = TICK_WIDTH'(1);
    localparam logic [ROW_ADDR_WIDTH-1:0] ONE_ROW   = ROW_ADDR_WIDTH'(1);

    state_t                    state;
    state_t                    state_nxt;
    logic [TICK_WIDTH-1:0]     timer;
    logic [TICK_WIDTH-1:0]     period_m1;
    logic [ROW_ADDR_WIDTH-1:0] row;
    logic [ROW_ADDR_WIDTH-1:0] row_inc;
    logic [ROW_ADDR_WIDTH-1:0] row_nxt;
    logic [1:0]                cmd;
    logic [3:0]                row_vol;
    logic                      unused_row_bits;

    assign unused_row_bits = ^row_data[2:0];
    assign row_addr        = row;

    always_comb begin
        period_m1 = (ticks_per_row < MIN_TICKS) ? (MIN_TICKS - ONE_TICK) : (ticks_per_row - ONE_TICK);
        // An increment past the top of the address space wraps to 0 on its own.
        row_inc   = row + ONE_ROW;
        row_nxt   = row_inc;
        if ((cmd == CMD_JUMP) || (row == last_row)) begin
            row_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_active_low) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        row_rd_en      = (state == S_FETCH);
        freq_rom_rd_en = (state == S_LOOKUP) && (cmd == CMD_NOTE_ON);
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (start) state_nxt = S_FETCH;
                S_FETCH:     state_nxt = S_DECODE;
                S_DECODE:    state_nxt = S_LOOKUP;
                S_LOOKUP:    state_nxt = S_APPLY;
                S_APPLY:     state_nxt = S_WAIT_TICK;
                S_WAIT_TICK: if (timer <= ONE_TICK) state_nxt = S_FETCH;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    // Loaded in FETCH so the next FETCH lands exactly one period later.
    always_ff @(posedge clk) begin
        if (!rst_active_low) begin
            timer <= '0;
        end else if (state == S_FETCH) begin
            timer <= period_m1;
        end else if ((state != S_IDLE) && (timer != '0)) begin
            timer <= timer - ONE_TICK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_active_low) begin
            row           <= '0;
            cmd           <= '0;
            row_vol       <= '0;
            freq_rom_addr <= '0;
            freq_word     <= '0;
            dds_phase_rst <= 1'b0;
            gate          <= 1'b0;
            volume        <= '0;
            running       <= 1'b0;
            row_strobe    <= 1'b0;
            current_row   <= '0;
        end else begin
            dds_phase_rst <= 1'b0;
            row_strobe    <= 1'b0;
            if (stop) begin
                gate    <= 1'b0;
                running <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            running <= 1'b1;
                            row     <= '0;
                        end
                    end
                    S_DECODE: begin
                        cmd           <= row_data[15:14];
                        freq_rom_addr <= row_data[13:7];
                        row_vol       <= row_data[6:3];
                    end
                    S_APPLY: begin
                        row_strobe  <= 1'b1;
                        current_row <= row;
                        row         <= row_nxt;
                        if (cmd == CMD_NOTE_ON) begin
                            freq_word     <= freq_rom_data;
                            gate          <= 1'b1;
                            volume        <= row_vol;
                            dds_phase_rst <= 1'b1;
                        end else if (cmd == CMD_NOTE_OFF) begin
                            gate <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tracker_channel_sequencer.sv
// Bench for tracker_channel_sequencer: directed playback table and corner sequences, then random
// start/stop/reset traffic checked every cycle against a row-age based reference model.
module tb_tracker_channel_sequencer;

    localparam int PW = 32;
    localparam int RW = 6;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_active_low;
    logic          start;
    logic          stop;
    logic [RW-1:0] last_row;
    logic [TW-1:0] ticks_per_row;
    logic [RW-1:0] row_addr;
    logic          row_rd_en;
    logic [15:0]   row_data;
    logic [6:0]    freq_rom_addr;
    logic          freq_rom_rd_en;
    logic [PW-1:0] freq_rom_data;
    logic [PW-1:0] freq_word;
    logic          dds_phase_rst;
    logic          gate;
    logic [3:0]    volume;
    logic          running;
    logic          row_strobe;
    logic [RW-1:0] current_row;

    logic [15:0] pat [0:63];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: playback described by the age of the current row (cycles since its fetch).
    logic          m_run = 1'b0;
    logic [RW-1:0] m_row = '0;
    logic [RW-1:0] m_cur = '0;
    logic [PW-1:0] m_fw = '0;
    logic          m_gate = 1'b0;
    logic [3:0]    m_vol = '0;
    logic          m_prst = 1'b0;
    logic          m_strobe = 1'b0;
    int            m_age = 0;
    int            m_period = 8;

    always #5 clk = ~clk;

    tracker_channel_sequencer #(.PHASE_WIDTH(PW), .ROW_ADDR_WIDTH(RW), .TICK_WIDTH(TW)) dut (
        .clk(clk), .rst_active_low(rst_active_low), .start(start), .stop(stop),
        .last_row(last_row), .ticks_per_row(ticks_per_row),
        .row_addr(row_addr), .row_rd_en(row_rd_en), .row_data(row_data),
        .freq_rom_addr(freq_rom_addr), .freq_rom_rd_en(freq_rom_rd_en), .freq_rom_data(freq_rom_data),
        .freq_word(freq_word), .dds_phase_rst(dds_phase_rst), .gate(gate), .volume(volume),
        .running(running), .row_strobe(row_strobe), .current_row(current_row)
    );

    function automatic logic [31:0] rom_word(input logic [6:0] n);
        return 32'(n) * 32'd1000;
    endfunction

    // Memories answer only the cycle after a read strobe; otherwise they present garbage.
    always @(posedge clk) begin
        if (row_rd_en) row_data <= pat[row_addr];
        else           row_data <= 16'($urandom);
        if (freq_rom_rd_en) freq_rom_data <= rom_word(freq_rom_addr);
        else                freq_rom_data <= $urandom;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach its end (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] outputs_now();
        return {row_rd_en, row_addr, freq_rom_rd_en, freq_word, dds_phase_rst, gate, volume,
                running, row_strobe, current_row};
    endfunction

    task automatic model_step();
        logic [15:0] w;
        if (!rst_active_low) begin
            m_run = 1'b0; m_row = '0; m_cur = '0; m_fw = '0; m_gate = 1'b0;
            m_vol = '0; m_prst = 1'b0; m_strobe = 1'b0; m_age = 0;
        end else if (stop) begin
            m_run = 1'b0; m_gate = 1'b0; m_prst = 1'b0; m_strobe = 1'b0;
        end else if (!m_run) begin
            m_prst = 1'b0; m_strobe = 1'b0;
            if (start) begin
                m_run = 1'b1; m_row = '0; m_age = 0;
            end
        end else begin
            m_prst = 1'b0; m_strobe = 1'b0;
            if (m_age == 0) m_period = (int'(ticks_per_row) < 8) ? 8 : int'(ticks_per_row);
            if (m_age == 3) begin
                w = pat[m_row];
                case (w[15:14])
                    2'b01: begin m_fw = rom_word(w[13:7]); m_gate = 1'b1; m_vol = w[6:3]; m_prst = 1'b1; end
                    2'b10: m_gate = 1'b0;
                    default: ;
                endcase
                m_strobe = 1'b1;
                m_cur = m_row;
                if ((w[15:14] == 2'b11) || (m_row == last_row)) m_row = '0;
                else m_row = RW'((int'(m_row) + 1) % 64);
            end
            m_age = (m_age + 1 >= m_period) ? 0 : m_age + 1;
        end
    endtask

    task automatic model_check();
        logic        exp_rd;
        logic        exp_frd;
        logic [15:0] w;
        w       = pat[m_row];
        exp_rd  = m_run && (m_age == 0);
        exp_frd = m_run && (m_age == 2) && (w[15:14] == 2'b01);
        check("model_outputs", outputs_now(),
              {exp_rd, m_row, exp_frd, m_fw, m_prst, m_gate, m_vol, m_run, m_strobe, m_cur});
        if (exp_frd) check("model_rom_addr", 64'(freq_rom_addr), 64'(w[13:7]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic start_play();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic stop_play();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    typedef struct {
        int          t;
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] fw;
        logic        g;
        logic [3:0]  vol;
        logic        prst;
        logic        stb;
    } vec_t;

    initial begin
        vec_t vt[13];
        int   t;
        int   last_f;
        int   nf;
        int   nrom;
        int   f_times[$];
        int   addrs[$];
        int   exp_seq[6];
        logic [1:0] c;

        vt[0]  = '{0,  1'b1, 6'd0, 32'd0,     1'b0, 4'd0, 1'b0, 1'b0};
        vt[1]  = '{3,  1'b0, 6'd0, 32'd0,     1'b0, 4'd0, 1'b0, 1'b0};
        vt[2]  = '{4,  1'b0, 6'd1, 32'd10000, 1'b1, 4'd9, 1'b1, 1'b1};
        vt[3]  = '{5,  1'b0, 6'd1, 32'd10000, 1'b1, 4'd9, 1'b0, 1'b0};
        vt[4]  = '{20, 1'b1, 6'd1, 32'd10000, 1'b1, 4'd9, 1'b0, 1'b0};
        vt[5]  = '{24, 1'b0, 6'd2, 32'd10000, 1'b1, 4'd9, 1'b0, 1'b1};
        vt[6]  = '{40, 1'b1, 6'd2, 32'd10000, 1'b1, 4'd9, 1'b0, 1'b0};
        vt[7]  = '{43, 1'b0, 6'd2, 32'd10000, 1'b1, 4'd9, 1'b0, 1'b0};
        vt[8]  = '{44, 1'b0, 6'd3, 32'd10000, 1'b0, 4'd9, 1'b0, 1'b1};
        vt[9]  = '{60, 1'b1, 6'd3, 32'd10000, 1'b0, 4'd9, 1'b0, 1'b0};
        vt[10] = '{64, 1'b0, 6'd0, 32'd10000, 1'b0, 4'd9, 1'b0, 1'b1};
        vt[11] = '{80, 1'b1, 6'd0, 32'd10000, 1'b0, 4'd9, 1'b0, 1'b0};
        vt[12] = '{84, 1'b0, 6'd1, 32'd10000, 1'b1, 4'd9, 1'b1, 1'b1};

        for (int i = 0; i < 64; i++) pat[i] = 16'h0000;
        pat[0] = {2'b01, 7'd10, 4'd9,  3'd0};
        pat[1] = {2'b00, 7'd20, 4'd3,  3'd5};
        pat[2] = {2'b10, 7'd30, 4'd1,  3'd0};
        pat[3] = {2'b00, 7'd5,  4'd15, 3'd7};

        // Reset held two cycles with start asserted.
        rst_active_low = 1'b0; start = 1'b1; stop = 1'b0; last_row = 6'd3; ticks_per_row = 24'd20;
        tick(); tick();
        check("reset_outputs", outputs_now(), 64'd0);
        check("reset_rom_addr", 64'(freq_rom_addr), 64'd0);
        rst_active_low = 1'b1; start = 1'b0;
        tick();
        check("idle_after_reset", {63'd0, row_rd_en}, 64'd0);

        // Basic playback against the hand-computed table.
        start_play();
        t = 0;
        for (int i = 0; i < 13; i++) begin
            while (t < vt[i].t) begin tick(); t++; end
            check($sformatf("playback[%0d]", i),
                  {row_rd_en, row_addr, freq_word, gate, volume, dds_phase_rst, row_strobe},
                  {vt[i].rd, vt[i].addr, vt[i].fw, vt[i].g, vt[i].vol, vt[i].prst, vt[i].stb});
        end
        stop_play();

        // Minimum period: short settings are stretched to 8 cycles.
        pat[0] = {2'b00, 7'd3,  4'd2, 3'd0};
        pat[1] = {2'b01, 7'd20, 4'd4, 3'd0};
        ticks_per_row = 24'd3;
        start_play();
        last_f = cyc; nf = 1; nrom = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (row_rd_en) begin
                check("min_period_spacing", 64'(cyc - last_f), 64'd8);
                last_f = cyc; nf++;
            end
            if (freq_rom_rd_en) begin
                nrom++;
                check("rom_rd_only_note_on", 64'(row_addr), 64'd1);
            end
        end
        check("min_period_fetches", 64'(nf), 64'd6);
        check("min_period_rom_reads", 64'(nrom), 64'd1);
        stop_play();

        // JUMP on row 2 returns to row 0 despite last_row = 7.
        pat[0] = {2'b01, 7'd7,   4'd5, 3'd0};
        pat[1] = {2'b00, 7'd1,   4'd1, 3'd0};
        pat[2] = {2'b11, 7'd100, 4'd2, 3'd0};
        last_row = 6'd7; ticks_per_row = 24'd0;
        exp_seq = '{0, 1, 2, 0, 1, 2};
        start_play();
        addrs.push_back(int'(row_addr));
        for (int i = 0; i < 100 && addrs.size() < 6; i++) begin
            tick();
            if (row_rd_en) addrs.push_back(int'(row_addr));
            if (row_strobe && current_row == 6'd2)
                check("jump_row_holds", {freq_word, gate, volume}, {32'd7000, 1'b1, 4'd5});
        end
        check("jump_fetch_count", 64'(addrs.size()), 64'd6);
        for (int i = 0; i < addrs.size() && i < 6; i++)
            check($sformatf("jump_addr[%0d]", i), 64'(addrs[i]), 64'(exp_seq[i]));
        stop_play();

        // stop during LOOKUP of a NOTE_ON row: nothing is applied.
        pat[0] = {2'b01, 7'd50, 4'd12, 3'd0};
        last_row = 6'd3; ticks_per_row = 24'd20;
        start_play();
        tick(); tick();
        check("lookup_rom_rd", {63'd0, freq_rom_rd_en}, 64'd1);
        stop_play();
        check("stop_run_gate", {62'd0, running, gate}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stop_no_apply", {freq_word, dds_phase_rst, row_strobe}, {32'd7000, 1'b0, 1'b0});
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", {63'd0, running}, 64'd0);
        tick();
        check("start_stop_no_fetch", {63'd0, row_rd_en}, 64'd0);

        // Period change mid-row only affects the next row.
        start_play();
        f_times.push_back(cyc);
        for (int i = 0; i < 60 && f_times.size() < 3; i++) begin
            if (i == 10) ticks_per_row = 24'd12;
            tick();
            if (row_rd_en) f_times.push_back(cyc);
        end
        check("period_change_count", 64'(f_times.size()), 64'd3);
        if (f_times.size() == 3) begin
            check("period_old", 64'(f_times[1] - f_times[0]), 64'd20);
            check("period_new", 64'(f_times[2] - f_times[1]), 64'd12);
        end
        stop_play();

        // Random traffic with occasional reset, stop, and setting changes.
        for (int i = 0; i < 64; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            pat[i] = {c, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
        end
        for (int i = 0; i < 4000; i++) begin
            start          = ($urandom_range(0, 29) == 0);
            stop           = ($urandom_range(0, 199) == 0);
            rst_active_low = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 49) == 0) ticks_per_row = TW'($urandom_range(0, 30));
            if ($urandom_range(0, 99) == 0) last_row = RW'($urandom_range(0, 63));
            tick();
        end
        rst_active_low = 1'b1; start = 1'b0;
        stop_play();

        // Long run across the full row space to exercise the top-of-range wrap.
        for (int i = 0; i < 64; i++)
            pat[i] = {2'($urandom_range(0, 2)), 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 3'd0};
        last_row = 6'd63; ticks_per_row = 24'd8;
        start_play();
        for (int i = 0; i < 600; i++) tick();
        stop_play();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tracker_channel_sequencer.md
# tracker_channel_sequencer

Row sequencer for one tracker voice. Steps through a pattern RAM at a programmable row period, decodes each row's command, converts note numbers to DDS frequency words through an external frequency ROM, and drives the triangle DDS channel's frequency word, phase restart, gate and volume. Sits between the pattern memory/frequency ROM and one DDS oscillator channel.

## Interface
- PHASE_WIDTH, 32, width of frequency word and frequency ROM data
- ROW_ADDR_WIDTH, 6, pattern row address width
- TICK_WIDTH, 24, width of the row-period setting, in clock cycles
- clk  in  1  system clock
- rst_active_low  in  1  reset, synchronous, active-low
- start  in  1  pulse; begins playback at row 0
- stop  in  1  pulse; halts playback
- last_row  in  ROW_ADDR_WIDTH  index of final row before wrap to 0
- ticks_per_row  in  TICK_WIDTH  row period in cycles; values below 8 are treated as 8
- row_addr  out  ROW_ADDR_WIDTH  pattern RAM address
- row_rd_en  out  1  pattern RAM read strobe
- row_data  in  16  pattern RAM data, valid the cycle after row_rd_en
- freq_rom_addr  out  7  note number to frequency ROM
- freq_rom_rd_en  out  1  frequency ROM read strobe
- freq_rom_data  in  PHASE_WIDTH  frequency word, valid the cycle after freq_rom_rd_en
- freq_word  out  PHASE_WIDTH  to DDS frequency input
- dds_phase_rst  out  1  one-cycle active-high pulse restarting the DDS phase
- gate  out  1  channel audible
- volume  out  4  channel volume
- running  out  1  playback active
- row_strobe  out  1  one-cycle pulse when a row's effect is applied
- current_row  out  ROW_ADDR_WIDTH  row most recently applied

## Operation
- Row format: [15:14] cmd, [13:7] note, [6:3] volume, [2:0] ignored.
- cmd 00 HOLD: freq_word, gate, volume unchanged.
- cmd 01 NOTE_ON: freq_word <= ROM word for note; gate <= 1; volume <= row volume; dds_phase_rst pulses.
- cmd 10 NOTE_OFF: gate <= 0; freq_word and volume retained.
- cmd 11 JUMP: no output change; next row is 0 regardless of last_row.
- Next row otherwise: row+1, or 0 when row == last_row. Wrap is also forced if row+1 overflows ROW_ADDR_WIDTH.
- FSM states:
  - IDLE: start -> FETCH with row = 0, running <= 1.
  - FETCH: row_rd_en = 1; row timer loaded with max(ticks_per_row, 8) - 1; -> DECODE.
  - DECODE: latch row_data -> LOOKUP.
  - LOOKUP: freq_rom_rd_en = 1 only for NOTE_ON; the state is always occupied -> APPLY.
  - APPLY: register outputs per cmd; compute next row -> WAIT_TICK.
  - WAIT_TICK: timer reaches 0 -> FETCH.
- The row timer decrements every cycle outside IDLE.
- ticks_per_row is sampled only in FETCH. last_row is sampled in APPLY.
- stop, in any state: -> IDLE next cycle; gate <= 0; running <= 0; freq_word and volume retained; no row_strobe.
- stop and start in the same cycle: stop wins.
- start while running is ignored.

## Timing
- Reset, when rst_active_low is low at a clk edge: state IDLE; freq_word, dds_phase_rst, gate, volume, running, row_strobe, current_row, row_addr, row_rd_en, freq_rom_addr and freq_rom_rd_en all 0; row timer 0.
- Reset mid-row abandons any fetch in flight without applying it.
- start sampled at edge E: FETCH is the cycle after E, and running is 1 from that same cycle.
- Relative to FETCH cycle F, the row is applied at the end of F+3, so outputs change from F+4.
- row_strobe and dds_phase_rst are high in F+4 only. current_row updates in F+4.
- Row period is exactly max(ticks_per_row, 8) cycles, FETCH to FETCH, with no drift.
- row_addr is stable while row_rd_en is high. freq_rom_addr is stable while freq_rom_rd_en is high.
- Outputs are held in WAIT_TICK and IDLE.

## Test plan
- Reset: hold rst_active_low low 2 cycles with start high -> all outputs 0, running 0, no row_rd_en.
- Basic playback: last_row=3, ticks_per_row=20, rows NOTE_ON n=10 v=9 / HOLD / NOTE_OFF / HOLD, ROM word = n*1000, start -> row_rd_en every 20 cycles at addresses 0,1,2,3,0; freq_word=10000, gate=1, volume=9 and dds_phase_rst pulse 4 cycles after the first FETCH; gate=0 from 44 cycles after the first FETCH; rows wrap to 0.
- Minimum period: ticks_per_row=3 -> FETCH spacing of exactly 8 cycles; freq_rom_rd_en is seen only on NOTE_ON rows.
- JUMP: last_row=7, row 2 = cmd 11 -> address sequence 0,1,2,0,1,2; outputs unchanged on row 2.
- stop during LOOKUP of a NOTE_ON row -> freq_word not updated; gate=0, running=0 next cycle; no dds_phase_rst. start and stop in the same cycle while IDLE -> remains IDLE.
- Parameter change: change ticks_per_row from 20 to 12 during WAIT_TICK -> current row keeps 20 cycles; the next row lasts 12 cycles.
